lsu_dmem_master: RTL and testbench

//  Initiator side of the core's data-memory request/valid protocol (the PROC_REQ/MEM_RDY/VALID responder
//  is the data memory wrapper). Turns pipeline load/store ops (byte/half/word) into word-aligned bus

---
 rtl/lsu_dmem_master_if.sv | 31 +++
 rtl/lsu_dmem_master.sv | 146 ++++++++++++++
 tb/tb_lsu_dmem_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_master_if.sv
// lsu_dmem_master_if
//   Data-memory request/valid bus between the load/store unit (master) and
//   the data memory wrapper (slave).
//   dproc_req  master->slave  request strobe, held until accepted
//   daddr      master->slave  word-aligned byte address
//   wenMem     master->slave  1 = write
//   wdata2mem  master->slave  write data (full word, no byte enables)
//   dmem_rdy   slave->master  request accepted when dproc_req & dmem_rdy
//   dvalid     slave->master  response / write-ack strobe
//   ddata      slave->master  read data, valid with dvalid
interface lsu_dmem_master_if #(
    parameter int nbits = 32
);
    logic             dproc_req;
    logic [nbits-1:0] daddr;
    logic             wenMem;
    logic [nbits-1:0] wdata2mem;
    logic             dmem_rdy;
    logic             dvalid;
    logic [nbits-1:0] ddata;

    modport master (
        output dproc_req, daddr, wenMem, wdata2mem,
        input  dmem_rdy, dvalid, ddata
    );

    modport slave (
        input  dproc_req, daddr, wenMem, wdata2mem,
        output dmem_rdy, dvalid, ddata
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master
//   Converts pipeline byte/half/word loads and stores into word-aligned
//   transactions on the data-memory request/valid bus, one outstanding at a
//   time. Sub-word stores are read-modify-write since memory has no byte
//   enables. Optional timeout aborts a stuck bus transaction with an error.
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   ls_req ..      pipeline op: we, size (00 b/01 h/10 w), unsigned, addr, wdata
//   ls_stall       pipeline must hold the op
//   ls_done        one-cycle completion pulse with ls_rdata / ls_err
//   bus            master side of lsu_dmem_master_if
module lsu_dmem_master #(
    parameter int          nbits   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [1:0]       ls_size,
    input  logic             ls_unsigned,
    input  logic [nbits-1:0] ls_addr,
    input  logic [nbits-1:0] ls_wdata,
    output logic             ls_stall,
    output logic             ls_done,
    output logic [nbits-1:0] ls_rdata,
    output logic             ls_err,
    lsu_dmem_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, word_q, rdata_q;
    logic        err_q;
    logic [31:0] tmo_cnt;

    logic in_bus, accept, rd_resp, wr_resp, tmo, illegal, abort;

    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) r[{a, 3'b000} +: 8] = d[7:0];
        else             r[{a[1], 4'b0000} +: 16] = d[15:0];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return w;
        endcase
    endfunction

    assign in_bus  = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ) || (state == WR_WAIT);
    assign accept  = bus.dproc_req & bus.dmem_rdy;
    // A zero-wait responder may strobe dvalid in the accept cycle itself.
    assign rd_resp = bus.dvalid & ((state == RD_WAIT) | ((state == RD_REQ) & accept));
    assign wr_resp = bus.dvalid & ((state == WR_WAIT) | ((state == WR_REQ) & accept));
    assign tmo     = (TIMEOUT != 0) && in_bus && (tmo_cnt == TIMEOUT - 1);
    assign illegal = (ls_size == 2'b11) | ((ls_size == 2'b01) & ls_addr[0]) |
                     ((ls_size == 2'b10) & (ls_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Progress always wins over a timeout expiring in the same cycle.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE: if (ls_req) begin
                if (illegal)                           state_next = DONE;
                else if (!ls_we || ls_size != 2'b10)   state_next = RD_REQ;
                else                                   state_next = WR_REQ;
            end
            RD_REQ, RD_WAIT: begin
                if (rd_resp)                           state_next = we_q ? WR_REQ : DONE;
                else if (accept)                       state_next = RD_WAIT;
                else if (tmo) begin state_next = DONE; abort = 1'b1; end
            end
            WR_REQ, WR_WAIT: begin
                if (wr_resp)                           state_next = DONE;
                else if (accept)                       state_next = WR_WAIT;
                else if (tmo) begin state_next = DONE; abort = 1'b1; end
            end
            DONE:                                      state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.dproc_req = (state == RD_REQ) || (state == WR_REQ);
        bus.wenMem    = (state == WR_REQ);
        bus.daddr     = {addr_q[31:2], 2'b00};
        bus.wdata2mem = word_q;
        // Gated by rst so the stall also drops asynchronously in reset.
        ls_stall      = ((state == IDLE) & ls_req & rst) | in_bus;
        ls_done       = (state == DONE);
        ls_rdata      = (state == DONE) ? rdata_q : '0;
        ls_err        = (state == DONE) & err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (state_next != state) tmo_cnt <= '0;
            else if (in_bus)         tmo_cnt <= tmo_cnt + 32'd1;

            if (state == IDLE && ls_req) begin
                we_q    <= ls_we;
                uns_q   <= ls_unsigned;
                size_q  <= ls_size;
                addr_q  <= ls_addr;
                word_q  <= ls_wdata;
                rdata_q <= '0;
                err_q   <= illegal;
            end else if (rd_resp) begin
                if (we_q) word_q  <= merge_lane(bus.ddata, word_q, size_q, addr_q[1:0]);
                else      rdata_q <= extract(bus.ddata, size_q, uns_q, addr_q[1:0]);
            end else if (abort) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ls_req = 1'b0, ls_req2 = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
    logic [1:0]  ls_size = 2'b10;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic        ls_stall, ls_done, ls_err, ls_stall2, ls_done2, ls_err2;
    logic [31:0] ls_rdata, ls_rdata2;

    lsu_dmem_master_if #(.nbits(32)) bus1();
    lsu_dmem_master_if #(.nbits(32)) bus2();

    lsu_dmem_master #(.nbits(32), .TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_stall(ls_stall), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .bus(bus1.master)
    );

    lsu_dmem_master #(.nbits(32), .TIMEOUT(5)) dut_tmo (
        .clk(clk), .rst(rst), .ls_req(ls_req2), .ls_we(ls_we), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_stall(ls_stall2), .ls_done(ls_done2), .ls_rdata(ls_rdata2), .ls_err(ls_err2),
        .bus(bus2.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responder model for bus1: memory of 64 words indexed by daddr[7:2].
    logic [31:0] mem [0:63];
    int unsigned cfg_rdy_delay = 0, cfg_wait = 0;
    bit          cfg_zero = 0;
    int unsigned n_accept = 0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic        last_we = 1'b0;

    task automatic mem_respond(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus1.dvalid = 1'b1;
        if (we) mem[a[7:2]] = d;
        else    bus1.ddata = mem[a[7:2]];
    endtask

    initial begin
        int unsigned hold, wcnt;
        bit          pend;
        logic        pwe;
        logic [31:0] paddr, pdata;
        hold = 0; wcnt = 0; pend = 0; pwe = 0; paddr = '0; pdata = '0;
        bus1.dmem_rdy = 1'b1; bus1.dvalid = 1'b0; bus1.ddata = '0;
        forever begin
            @(negedge clk);
            bus1.dvalid = 1'b0;
            if (pend) begin
                if (wcnt == 0) begin mem_respond(pwe, paddr, pdata); pend = 0; end
                else wcnt--;
            end
            if (bus1.dproc_req && !pend) begin
                if (hold == 0) paddr = bus1.daddr;
                else check_eq("addr_stable", bus1.daddr, paddr);
                if (hold < cfg_rdy_delay) begin
                    bus1.dmem_rdy = 1'b0;
                    hold++;
                end else begin
                    bus1.dmem_rdy = 1'b1;
                    hold = 0;
                    n_accept++;
                    pwe = bus1.wenMem; pdata = bus1.wdata2mem;
                    last_addr = paddr; last_we = pwe; last_wdata = pdata;
                    if (cfg_zero) mem_respond(pwe, paddr, pdata);
                    else begin pend = 1; wcnt = cfg_wait; end
                end
            end else begin
                bus1.dmem_rdy = 1'b1;
            end
        end
    end

    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int unsigned cyc, output logic [31:0] rd,
                         output logic er, output logic st0);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
        #1 st0 = ls_stall;
        cyc = 0; rd = '0; er = 1'b0;
        do begin @(posedge clk); #1; cyc++; end while (!ls_done && cyc < 60);
        check_eq("done_seen", {31'd0, ls_done}, 32'd1);
        rd = ls_rdata; er = ls_err;
        check_eq("stall_in_done", {31'd0, ls_stall}, 32'd0);
        ls_req = 1'b0;
        @(posedge clk); #1;
        check_eq("done_pulse", {31'd0, ls_done}, 32'd0);
    endtask

    initial begin
        int unsigned cyc, acc0, dones;
        logic [31:0] rd;
        logic er, st0;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        bus2.dmem_rdy = 1'b0; bus2.dvalid = 1'b0; bus2.ddata = '0;

        // reset state
        #12;
        check_eq("rst_stall", {31'd0, ls_stall}, 32'd0);
        check_eq("rst_done", {31'd0, ls_done}, 32'd0);
        check_eq("rst_req", {31'd0, bus1.dproc_req}, 32'd0);
        check_eq("rst_daddr", bus1.daddr, 32'd0);
        check_eq("rst_req2", {31'd0, bus2.dproc_req}, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: load word
        mem[0] = 32'hDEADBEEF; acc0 = n_accept;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, '0, cyc, rd, er, st0);
        check_eq("lw_lat", cyc, 3);
        check_eq("lw_data", rd, 32'hDEADBEEF);
        check_eq("lw_err", {31'd0, er}, 0);
        check_eq("lw_stall0", {31'd0, st0}, 1);
        check_eq("lw_naccept", n_accept - acc0, 1);
        check_eq("lw_addr", last_addr, 32'h100);
        check_eq("lw_we", {31'd0, last_we}, 0);

        // 2: sub-word loads and extension
        mem[0] = 32'h80112233;
        do_op(1'b0, 2'b00, 1'b0, 32'h103, '0, cyc, rd, er, st0);
        check_eq("lb_s", rd, 32'hFFFFFF80);
        do_op(1'b0, 2'b00, 1'b1, 32'h103, '0, cyc, rd, er, st0);
        check_eq("lb_u", rd, 32'h00000080);
        do_op(1'b0, 2'b01, 1'b1, 32'h102, '0, cyc, rd, er, st0);
        check_eq("lh_u", rd, 32'h00008011);
        do_op(1'b0, 2'b01, 1'b0, 32'h102, '0, cyc, rd, er, st0);
        check_eq("lh_s", rd, 32'hFFFF8011);
        do_op(1'b0, 2'b00, 1'b0, 32'h100, '0, cyc, rd, er, st0);
        check_eq("lb_lane0", rd, 32'h00000033);

        // 3: sub-word stores (read-modify-write) and word store
        mem[0] = 32'h11223344; acc0 = n_accept;
        do_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, cyc, rd, er, st0);
        check_eq("sb_lat", cyc, 5);
        check_eq("sb_naccept", n_accept - acc0, 2);
        check_eq("sb_wdata", last_wdata, 32'h1122AB44);
        check_eq("sb_we", {31'd0, last_we}, 1);
        check_eq("sb_mem", mem[0], 32'h1122AB44);
        check_eq("sb_err", {31'd0, er}, 0);
        do_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF, cyc, rd, er, st0);
        check_eq("sh_mem", mem[0], 32'hBEEFAB44);
        acc0 = n_accept;
        do_op(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFEF00D, cyc, rd, er, st0);
        check_eq("sw_lat", cyc, 3);
        check_eq("sw_naccept", n_accept - acc0, 1);
        check_eq("sw_mem", mem[2], 32'hCAFEF00D);

        // 4: illegal ops, no bus access
        acc0 = n_accept;
        do_op(1'b0, 2'b10, 1'b0, 32'h102, '0, cyc, rd, er, st0);
        check_eq("mis_lat", cyc, 1);
        check_eq("mis_err", {31'd0, er}, 1);
        check_eq("mis_stall0", {31'd0, st0}, 1);
        do_op(1'b0, 2'b11, 1'b0, 32'h100, '0, cyc, rd, er, st0);
        check_eq("sz11_err", {31'd0, er}, 1);
        do_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h5555, cyc, rd, er, st0);
        check_eq("sh_mis_err", {31'd0, er}, 1);
        check_eq("illegal_naccept", n_accept - acc0, 0);
        check_eq("illegal_mem", mem[0], 32'hBEEFAB44);

        // 5: slow responder, then zero-wait responder
        cfg_rdy_delay = 4; cfg_wait = 3; acc0 = n_accept;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, '0, cyc, rd, er, st0);
        check_eq("slow_lat", cyc, 10);
        check_eq("slow_data", rd, 32'hBEEFAB44);
        check_eq("slow_naccept", n_accept - acc0, 1);
        cfg_rdy_delay = 0; cfg_wait = 0; cfg_zero = 1;
        do_op(1'b0, 2'b10, 1'b0, 32'h108, '0, cyc, rd, er, st0);
        check_eq("zw_lat", cyc, 2);
        check_eq("zw_data", rd, 32'hCAFEF00D);
        do_op(1'b1, 2'b00, 1'b0, 32'h10B, 32'h12, cyc, rd, er, st0);
        check_eq("zw_sb_lat", cyc, 3);
        check_eq("zw_sb_mem", mem[2], 32'h12FEF00D);
        cfg_zero = 0;

        // 5b: timeout instance, responder never ready
        @(negedge clk);
        ls_req2 = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check_eq("tmo_req_hi", {31'd0, bus2.dproc_req}, 1);
        end while (!ls_done2 && cyc < 40);
        ls_req2 = 1'b0;
        check_eq("tmo_lat", cyc, 6);
        check_eq("tmo_err", {31'd0, ls_err2}, 1);
        check_eq("tmo_rdata", ls_rdata2, 0);
        check_eq("tmo_req_lo", {31'd0, bus2.dproc_req}, 0);
        @(negedge clk); bus2.dvalid = 1'b1; bus2.ddata = 32'hFFFFFFFF;
        @(negedge clk); bus2.dvalid = 1'b0;
        dones = 0;
        repeat (4) begin @(posedge clk); #1; if (ls_done2 || ls_stall2) dones++; end
        check_eq("tmo_late_dvalid", dones, 0);

        // 6: async reset in RD_WAIT, stale dvalid ignored afterwards
        cfg_wait = 3;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h100;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rw_stall_pre", {31'd0, ls_stall}, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_stall", {31'd0, ls_stall}, 0);
        check_eq("arst_daddr", bus1.daddr, 0);
        check_eq("arst_req", {31'd0, bus1.dproc_req}, 0);
        ls_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        dones = 0;
        repeat (6) begin @(posedge clk); #1; if (ls_done || ls_stall) dones++; end
        check_eq("stale_dvalid", dones, 0);
        cfg_wait = 0;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, '0, cyc, rd, er, st0);
        check_eq("post_rst_lat", cyc, 3);
        check_eq("post_rst_data", rd, 32'hBEEFAB44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
